// File: rtl/isa_joy_pkg.sv
// -----------------------------------------------------------------------------
// isa_joy_pkg
// Shared definitions for the ISA joystick hub: register offsets inside the
// 16-byte I/O window, the event FIFO entry layout, the FIFO status byte
// layout and the control register layout.
// Optional feature macro used by the users of this package: JOY_EVENT_FIFO_EN.
// -----------------------------------------------------------------------------
package isa_joy_pkg;

   // Offsets of the event/control registers; offsets 0..7 are channel pairs
   localparam logic [3:0] OFF_EVT_LO    = 4'h8;
   localparam logic [3:0] OFF_EVT_HI    = 4'h9;
   localparam logic [3:0] OFF_FIFO_STAT = 4'hA;
   localparam logic [3:0] OFF_CTRL      = 4'hB;

   // One queued button-change event; low byte is popped, high byte peeked
   typedef struct packed {
      logic [1:0]  chan;
      logic [1:0]  rsvd;
      logic [11:0] status;
   } joy_event_t;

   // Byte returned from the FIFO status register
   typedef struct packed {
      logic       empty;
      logic       full;
      logic       overflow;
      logic [4:0] count;
   } fifo_status_t;

   // Byte written to the control register
   typedef struct packed {
      logic [5:0] rsvd;
      logic       flush;
      logic       irq_en;
   } ctrl_t;

   function automatic logic [7:0] pack_fifo_status(input logic       empty,
                                                   input logic       full,
                                                   input logic       overflow,
                                                   input logic [4:0] count);
      fifo_status_t s;
      s.empty    = empty;
      s.full     = full;
      s.overflow = overflow;
      s.count    = count;
      return s;
   endfunction

endpackage

// File: rtl/joy_event_fifo.sv
// -----------------------------------------------------------------------------
// joy_event_fifo
// Synchronous FIFO of joy_event_t entries with occupancy count. A push while
// full is accepted only when a pop happens in the same cycle; flush empties
// the FIFO and takes priority over push/pop.
// Ports:
//   clk14, reset         clock, asynchronous active-high reset
//   push, wdata          write request and entry
//   pop, rdata           read request and head entry (valid when !empty)
//   flush                one-shot clear of pointers and count
//   count, empty, full   occupancy
// -----------------------------------------------------------------------------
module joy_event_fifo
   import isa_joy_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk14,
   input  logic                     reset,
   input  logic                     push,
   input  joy_event_t               wdata,
   input  logic                     pop,
   input  logic                     flush,
   output joy_event_t               rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   joy_event_t    mem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = mem[rptr_q];

   // When full, a push only fits if the head leaves in the same cycle; the
   // head is read combinationally before the slot is overwritten.
   always_comb begin
      pop_ok  = pop & ~empty & ~flush;
      push_ok = push & (~full | pop_ok) & ~flush;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok)  rptr_d = rptr_q + 1'b1;
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage array, contents are don't-care until written
   always_ff @(posedge clk14) begin
      if (push_ok) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/isa_joy_hub.sv
// -----------------------------------------------------------------------------
// isa_joy_hub
// ISA I/O slave exposing up to four joystick channels in a 16-byte window.
// Offsets 2i/2i+1 return channel i status low byte and a shadowed
// {type,2'b00,status[11:8]} captured on the 2i read. With JOY_EVENT_FIFO_EN
// defined, button changes are queued as events (0x8 pop, 0x9 peek, 0xA status,
// 0xB control) and an interrupt is raised; otherwise 0x8..0xB read 0x00,
// writes are ignored and irq is tied low.
// Ports:
//   clk14, reset          14 MHz ISA clock, asynchronous active-high reset
//   ior_n, iow_n, a       asynchronous ISA strobes and address
//   d_in, d_out, d_oe     write data, read data, data bus drive enable
//   joy_status, joy_type  packed per-channel buttons (12b) and type (2b)
//   joy_valid             per-channel new-sample pulse
//   irq                   level interrupt
// -----------------------------------------------------------------------------
module isa_joy_hub
   import isa_joy_pkg::*;
#(
   parameter int          NUM_JOY    = 2,
   parameter logic [15:0] BASE_ADDR  = 16'h0250,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic                  clk14,
   input  logic                  reset,
   input  logic                  ior_n,
   input  logic                  iow_n,
   input  logic [15:0]           a,
   input  logic [7:0]            d_in,
   output logic [7:0]            d_out,
   output logic                  d_oe,
   input  logic [NUM_JOY*12-1:0] joy_status,
   input  logic [NUM_JOY*2-1:0]  joy_type,
   input  logic [NUM_JOY-1:0]    joy_valid,
   output logic                  irq
);

   logic [1:0]  ior_sync_q, ior_sync_d;
   logic [1:0]  iow_sync_q, iow_sync_d;
   logic        ior_prev_q, ior_prev_d;
   logic        iow_prev_q, iow_prev_d;
   logic [7:0]  d_out_q, d_out_d;
   logic        d_oe_q, d_oe_d;
   logic [5:0]  shadow_q [NUM_JOY];
   logic [5:0]  shadow_d [NUM_JOY];
   logic [11:0] stat [NUM_JOY];
   logic [1:0]  typ [NUM_JOY];
   logic        ior_s;
   logic        iow_s;
   logic        addr_hit;
   logic        rd_start;
   logic        wr_start;
   logic [3:0]  offset;
   logic [7:0]  evt_byte;

   for (genvar g = 0; g < NUM_JOY; g++) begin : g_unpack
      assign stat[g] = joy_status[g*12 +: 12];
      assign typ[g]  = joy_type[g*2 +: 2];
   end

   assign ior_s    = ior_sync_q[1];
   assign iow_s    = iow_sync_q[1];
   assign offset   = a[3:0];
   assign addr_hit = (a[15:4] == BASE_ADDR[15:4]);
   assign rd_start = ior_prev_q & ~ior_s & addr_hit;
   assign wr_start = iow_prev_q & ~iow_s & addr_hit;
   assign d_out    = d_out_q;
   assign d_oe     = d_oe_q;

   // Bus front end: strobe synchronisers, read data capture and the odd-offset
   // shadow. The even read latches the upper half so the following odd read
   // returns a pair that belongs to the same sample.
   always_comb begin
      ior_sync_d = {ior_sync_q[0], ior_n};
      iow_sync_d = {iow_sync_q[0], iow_n};
      ior_prev_d = ior_s;
      iow_prev_d = iow_s;
      d_oe_d     = addr_hit & ~ior_s;
      d_out_d    = d_out_q;
      shadow_d   = shadow_q;
      if (rd_start) begin
         d_out_d = 8'h00;
         case (offset)
            OFF_EVT_LO, OFF_EVT_HI, OFF_FIFO_STAT, OFF_CTRL: d_out_d = evt_byte;
            default: begin
               for (int i = 0; i < NUM_JOY; i++) begin
                  if (offset[3:1] == 3'(i)) begin
                     if (offset[0]) begin
                        d_out_d = {shadow_q[i][5:4], 2'b00, shadow_q[i][3:0]};
                     end else begin
                        d_out_d     = stat[i][7:0];
                        shadow_d[i] = {typ[i], stat[i][11:8]};
                     end
                  end
               end
            end
         endcase
      end
   end

   // Bus front end registers; d_oe drops the instant reset asserts
   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         ior_sync_q <= 2'b11;
         iow_sync_q <= 2'b11;
         ior_prev_q <= 1'b1;
         iow_prev_q <= 1'b1;
         d_out_q    <= 8'h00;
         d_oe_q     <= 1'b0;
         for (int i = 0; i < NUM_JOY; i++) shadow_q[i] <= '0;
      end else begin
         ior_sync_q <= ior_sync_d;
         iow_sync_q <= iow_sync_d;
         ior_prev_q <= ior_prev_d;
         iow_prev_q <= iow_prev_d;
         d_out_q    <= d_out_d;
         d_oe_q     <= d_oe_d;
         shadow_q   <= shadow_d;
      end
   end

`ifdef JOY_EVENT_FIFO_EN

   localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [11:0]        last_q [NUM_JOY];
   logic [11:0]        last_d [NUM_JOY];
   logic [NUM_JOY-1:0] pending_q, pending_d;
   logic [NUM_JOY-1:0] set_mask, clear_mask;
   logic               overflow_q, overflow_d;
   logic               irq_en_q, irq_en_d;
   logic               irq_q, irq_d;
   logic               fifo_push, fifo_pop, fifo_flush;
   logic               fifo_empty, fifo_full;
   logic [COUNT_W-1:0] fifo_count;
   joy_event_t         push_entry, head;
   ctrl_t              ctrl_wr;
   logic               ctrl_hit;
   logic               stat_rd;
   logic               unused_ctrl;

   assign ctrl_wr     = ctrl_t'(d_in);
   assign unused_ctrl = ^ctrl_wr.rsvd;
   assign ctrl_hit    = wr_start & (offset == OFF_CTRL);
   assign stat_rd     = rd_start & (offset == OFF_FIFO_STAT);
   assign fifo_flush  = ctrl_hit & ctrl_wr.flush;
   assign fifo_pop    = rd_start & (offset == OFF_EVT_LO) & ~fifo_empty;
   assign irq         = irq_q;

   // Change detection, lowest-index arbitration and overflow/irq bookkeeping.
   // A channel whose event is pushed in the same cycle it changes again keeps
   // its pending bit, so the newer sample follows as its own event.
   always_comb begin
      last_d     = last_q;
      set_mask   = '0;
      clear_mask = '0;
      fifo_push  = 1'b0;
      push_entry = '0;
      for (int i = 0; i < NUM_JOY; i++) begin
         if (joy_valid[i] && (stat[i] != last_q[i])) begin
            set_mask[i] = 1'b1;
            last_d[i]   = stat[i];
         end
      end
      for (int i = NUM_JOY - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            fifo_push         = 1'b1;
            clear_mask        = '0;
            clear_mask[i]     = 1'b1;
            push_entry.chan   = 2'(i);
            push_entry.rsvd   = 2'b00;
            push_entry.status = last_q[i];
         end
      end
      pending_d = fifo_flush ? '0 : ((pending_q & ~clear_mask) | set_mask);
      if (fifo_flush) begin
         overflow_d = 1'b0;
      end else if (stat_rd) begin
         overflow_d = fifo_push & fifo_full & ~fifo_pop;
      end else begin
         overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);
      end
      irq_en_d = ctrl_hit ? ctrl_wr.irq_en : irq_en_q;
      irq_d    = irq_en_q & ~fifo_empty;
      evt_byte = 8'h00;
      case (offset)
         OFF_EVT_LO:    evt_byte = fifo_empty ? 8'h00 : head[7:0];
         OFF_EVT_HI:    evt_byte = fifo_empty ? 8'h00 : head[15:8];
         OFF_FIFO_STAT: evt_byte = pack_fifo_status(fifo_empty, fifo_full,
                                                    overflow_q, 5'(fifo_count));
         default:       evt_byte = 8'h00;
      endcase
   end

   // Event-side registers
   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_JOY; i++) last_q[i] <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         last_q     <= last_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
      end
   end

   joy_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk14 (clk14),
      .reset (reset),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

`else

   logic unused_inputs;

   assign unused_inputs = ^{d_in, joy_valid, wr_start};
   assign evt_byte      = 8'h00;
   assign irq           = 1'b0;

`endif

endmodule

// File: tb/tb_isa_joy_hub.sv
// -----------------------------------------------------------------------------
// tb_isa_joy_hub
// Directed bench for isa_joy_hub (NUM_JOY=2, BASE_ADDR=0x250, FIFO_DEPTH=16).
// Event FIFO steps are built only when JOY_EVENT_FIFO_EN is defined; otherwise
// the event/control window is checked to read 0x00 with irq held low.
// -----------------------------------------------------------------------------
module tb_isa_joy_hub;

   logic        clk14 = 1'b0;
   logic        reset = 1'b1;
   logic        ior_n = 1'b1;
   logic        iow_n = 1'b1;
   logic [15:0] a     = 16'h0000;
   logic [7:0]  d_in  = 8'h00;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [23:0] joy_status = '0;
   logic [3:0]  joy_type   = '0;
   logic [1:0]  joy_valid  = '0;
   logic        irq;
   int          total = 0;
   int          bad   = 0;

   isa_joy_hub #(
      .NUM_JOY    (2),
      .BASE_ADDR  (16'h0250),
      .FIFO_DEPTH (16)
   ) dut (
      .clk14      (clk14),
      .reset      (reset),
      .ior_n      (ior_n),
      .iow_n      (iow_n),
      .a          (a),
      .d_in       (d_in),
      .d_out      (d_out),
      .d_oe       (d_oe),
      .joy_status (joy_status),
      .joy_type   (joy_type),
      .joy_valid  (joy_valid),
      .irq        (irq)
   );

   // 14 MHz-ish clock
   always #35 clk14 = ~clk14;

   // One comparison, counted and reported on mismatch
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
      end
   endtask

   task automatic setChannel(input int ch, input logic [11:0] s, input logic [1:0] t);
      joy_status[ch*12 +: 12] = s;
      joy_type[ch*2 +: 2]     = t;
   endtask

   // One-cycle joy_valid pulse on the channels in mask, then settle time
   task automatic applyStimulus(input logic [1:0] mask);
      @(negedge clk14);
      joy_valid = mask;
      @(negedge clk14);
      joy_valid = '0;
      repeat (3) @(negedge clk14);
   endtask

   // Full in-window read: checks drive enable, data and bus release
   task automatic busRead(input logic [15:0] addr, input string tag,
                          input logic [7:0] expected);
      @(negedge clk14);
      a     = addr;
      ior_n = 1'b0;
      repeat (4) @(negedge clk14);
      checkOutput({tag, "_oe"}, 8'(d_oe), 8'h01);
      checkOutput(tag, d_out, expected);
      ior_n = 1'b1;
      repeat (4) @(negedge clk14);
      checkOutput({tag, "_rel"}, 8'(d_oe), 8'h00);
   endtask

   task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk14);
      a     = addr;
      d_in  = data;
      iow_n = 1'b0;
      repeat (4) @(negedge clk14);
      iow_n = 1'b1;
      repeat (4) @(negedge clk14);
   endtask

   initial begin
      logic [7:0] stat_after_reset;
      $display("[TB] start");

      // Reset state
      repeat (3) @(negedge clk14);
      checkOutput("rst_d_out", d_out, 8'h00);
      checkOutput("rst_d_oe", 8'(d_oe), 8'h00);
      checkOutput("rst_irq", 8'(irq), 8'h00);
      reset = 1'b0;
      repeat (3) @(negedge clk14);

      // Channel reads and shadow coherence
      setChannel(0, 12'hA5F, 2'b10);
      setChannel(1, 12'h7C3, 2'b11);
      busRead(16'h0251, "ch0_hi_noshadow", 8'h00);
      busRead(16'h0250, "ch0_lo", 8'h5F);
      setChannel(0, 12'h35F, 2'b01);
      busRead(16'h0251, "ch0_hi_coherent", 8'h8A);
      busRead(16'h0250, "ch0_lo_again", 8'h5F);
      busRead(16'h0251, "ch0_hi_new", 8'h43);
      busRead(16'h0252, "ch1_lo", 8'hC3);
      busRead(16'h0253, "ch1_hi", 8'hC7);
      busRead(16'h0254, "ch2_absent_lo", 8'h00);
      busRead(16'h0255, "ch2_absent_hi", 8'h00);
      busRead(16'h025C, "unused_off", 8'h00);

      // Out-of-window read never drives the bus
      @(negedge clk14);
      a     = 16'h0350;
      ior_n = 1'b0;
      repeat (5) @(negedge clk14);
      checkOutput("miss_oe", 8'(d_oe), 8'h00);
      ior_n = 1'b1;
      repeat (4) @(negedge clk14);

`ifdef JOY_EVENT_FIFO_EN
      stat_after_reset = 8'h80;
      busRead(16'h025A, "fifo_empty_init", 8'h80);

      // Two channels change in the same cycle: ch0 queued first
      setChannel(0, 12'h111, 2'b00);
      setChannel(1, 12'h222, 2'b01);
      applyStimulus(2'b11);
      busRead(16'h025A, "two_evt_stat", 8'h02);
      busRead(16'h0259, "evt0_peek", 8'h01);
      busRead(16'h0258, "evt0_pop", 8'h11);
      busRead(16'h0259, "evt1_peek", 8'h42);
      busRead(16'h0258, "evt1_pop", 8'h22);
      busRead(16'h025A, "two_evt_drained", 8'h80);

      // Unchanged sample is not an event; pop when empty is harmless
      applyStimulus(2'b01);
      busRead(16'h025A, "same_sample", 8'h80);
      busRead(16'h0258, "pop_empty", 8'h00);
      busRead(16'h025A, "pop_empty_stat", 8'h80);

      // Interrupt follows a pending event and clears after the pop
      busWrite(16'h025B, 8'h01);
      checkOutput("irq_en_empty", 8'(irq), 8'h00);
      setChannel(0, 12'h123, 2'b00);
      applyStimulus(2'b01);
      checkOutput("irq_set", 8'(irq), 8'h01);
      busRead(16'h0258, "irq_pop", 8'h23);
      checkOutput("irq_clear", 8'(irq), 8'h00);

      // Overflow: 17 changes into a 16-deep FIFO
      busWrite(16'h025B, 8'h02);
      busRead(16'h025A, "flush_stat", 8'h80);
      for (int k = 1; k <= 17; k++) begin
         setChannel(0, 12'h200 + 12'(k), 2'b00);
         applyStimulus(2'b01);
      end
      checkOutput("irq_disabled_full", 8'(irq), 8'h00);
      busRead(16'h025A, "ovf_stat", 8'h70);
      busRead(16'h025A, "ovf_cleared", 8'h50);
      busRead(16'h0258, "ovf_first_pop", 8'h01);
      busRead(16'h0259, "ovf_next_peek", 8'h02);
      busRead(16'h025A, "ovf_count15", 8'h0F);
      busWrite(16'h025B, 8'h02);
      busRead(16'h025A, "flush2_stat", 8'h80);

      // Leave one event queued ahead of the reset test
      setChannel(1, 12'h333, 2'b01);
      applyStimulus(2'b10);
`else
      stat_after_reset = 8'h00;
      setChannel(0, 12'h111, 2'b00);
      setChannel(1, 12'h222, 2'b01);
      applyStimulus(2'b11);
      busRead(16'h0258, "nofifo_evt_lo", 8'h00);
      busRead(16'h0259, "nofifo_evt_hi", 8'h00);
      busRead(16'h025A, "nofifo_stat", 8'h00);
      busRead(16'h025B, "nofifo_ctrl", 8'h00);
      busWrite(16'h025B, 8'h01);
      applyStimulus(2'b01);
      checkOutput("nofifo_irq", 8'(irq), 8'h00);
      busRead(16'h025A, "nofifo_stat_after_wr", 8'h00);
`endif

      // Reset asserted mid-read releases the bus at once
      @(negedge clk14);
      a     = 16'h0250;
      ior_n = 1'b0;
      repeat (4) @(negedge clk14);
      checkOutput("midrd_oe", 8'(d_oe), 8'h01);
      #10 reset = 1'b1;
      #1;
      checkOutput("midrd_rst_oe", 8'(d_oe), 8'h00);
      checkOutput("midrd_rst_dout", d_out, 8'h00);
      repeat (2) @(negedge clk14);
      ior_n = 1'b1;
      repeat (3) @(negedge clk14);
      reset = 1'b0;
      repeat (3) @(negedge clk14);
      checkOutput("post_rst_irq", 8'(irq), 8'h00);
      busRead(16'h025A, "post_rst_stat", stat_after_reset);
      busRead(16'h0251, "post_rst_shadow", 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
